mem_stage: RTL and testbench

Memory-access stage of the YPU pipeline, directly downstream of `ex`. It takes each instruction's ALU result and destination, plus load/store information, and performs any data-memory access byte-serially over the shared 8-bit memory port. While an access is in flight it holds the pipeline with a stall request. It presents registered write-back data to `wb` with a one-cycle `valid_o` pulse per completed instruction.

---
 rtl/mem_stage.sv | 196 +++++++++++++++++++
 tb/tb_mem_stage.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// mem_stage: YPU memory-access stage; does loads/stores byte-serially over the shared 8-bit memory port.
// Latency: 1 cycle for non-memory ops; 2N cycles for an N-byte load and N cycles for an N-byte store, plus grant wait.
// Backpressure: raises stall_req_o while an access is in flight; each byte request waits for mem_gnt_i.
//
// Ports: clk/rst (sync, active-low); upstream valid_i, rd_*_i, mem_op_i, mem_addr_i, store_data_i, stall_req_o;
//        write-back valid_o, rd_data_o, rd_addr_o, rd_enable_o (registered);
//        memory port mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o (combinational), mem_gnt_i, mem_rdata_i.
module mem_stage #(
    parameter int MEM_OP_LEN = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_i,
    input  logic [31:0]           rd_data_i,
    input  logic [4:0]            rd_addr_i,
    input  logic                  rd_enable_i,
    input  logic [MEM_OP_LEN-1:0] mem_op_i,
    input  logic [31:0]           mem_addr_i,
    input  logic [31:0]           store_data_i,
    output logic                  stall_req_o,
    output logic                  valid_o,
    output logic [31:0]           rd_data_o,
    output logic [4:0]            rd_addr_o,
    output logic                  rd_enable_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [31:0]           mem_addr_o,
    output logic [7:0]            mem_wdata_o,
    input  logic                  mem_gnt_i,
    input  logic [7:0]            mem_rdata_i
);

    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, RECV = 2'd2} state_t;

    state_t      state;
    state_t      state_nxt;
    logic [1:0]  cnt;
    logic [31:0] addr_q;
    logic [31:0] sdata_q;
    logic [31:0] load_buf;
    logic [31:0] load_asm;
    logic [31:0] load_ext;
    logic [4:0]  rd_addr_q;
    logic        rd_enable_q;
    logic        is_store_q;
    logic        signed_q;
    logic [1:0]  last_q;      // index of the final byte: N-1

    logic        in_mem;
    logic        in_store;
    logic        in_signed;
    logic [1:0]  in_last;
    logic        last_byte;
    logic        finish;

    // Decode of the incoming op; unknown codes fall through as non-memory.
    always_comb begin
        in_mem    = 1'b1;
        in_store  = 1'b0;
        in_signed = 1'b0;
        in_last   = 2'd0;
        case (int'(mem_op_i))
            1:       begin in_signed = 1'b1; in_last = 2'd0; end
            2:       begin in_signed = 1'b1; in_last = 2'd1; end
            3:       in_last = 2'd3;
            4:       in_last = 2'd0;
            5:       in_last = 2'd1;
            6:       begin in_store = 1'b1; in_last = 2'd0; end
            7:       begin in_store = 1'b1; in_last = 2'd1; end
            8:       begin in_store = 1'b1; in_last = 2'd3; end
            default: in_mem = 1'b0;
        endcase
    end

    assign last_byte = (cnt == last_q);
    assign finish    = ((state == REQ) && mem_gnt_i && is_store_q && last_byte) ||
                       ((state == RECV) && last_byte);

    // State register
    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (valid_i && in_mem) state_nxt = REQ;
            REQ: begin
                if (mem_gnt_i) begin
                    if (!is_store_q)    state_nxt = RECV;
                    else if (last_byte) state_nxt = IDLE;
                end
            end
            RECV:    state_nxt = last_byte ? IDLE : REQ;
            default: state_nxt = IDLE;
        endcase
    end

    // Memory port and stall; address/data forced to 0 when no request is out.
    // Stall is gated by rst so the cycle after a reset edge reads all-zero.
    always_comb begin
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = 32'd0;
        mem_wdata_o = 8'd0;
        if (state == REQ) begin
            mem_req_o   = 1'b1;
            mem_we_o    = is_store_q;
            mem_addr_o  = addr_q + {30'd0, cnt};
            mem_wdata_o = sdata_q[{cnt, 3'b000} +: 8];
        end
        stall_req_o = rst & (((state == IDLE) & valid_i & in_mem) |
                             ((state != IDLE) & ~finish));
    end

    // Final byte is merged straight from the port so the result is ready on the finishing edge.
    always_comb begin
        load_asm = load_buf;
        load_asm[{cnt, 3'b000} +: 8] = mem_rdata_i;
        case (last_q)
            2'd0:    load_ext = signed_q ? {{24{load_asm[7]}}, load_asm[7:0]}
                                         : {24'd0, load_asm[7:0]};
            2'd1:    load_ext = signed_q ? {{16{load_asm[15]}}, load_asm[15:0]}
                                         : {16'd0, load_asm[15:0]};
            default: load_ext = load_asm;
        endcase
    end

    // Datapath and write-back registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt         <= 2'd0;
            addr_q      <= 32'd0;
            sdata_q     <= 32'd0;
            load_buf    <= 32'd0;
            rd_addr_q   <= 5'd0;
            rd_enable_q <= 1'b0;
            is_store_q  <= 1'b0;
            signed_q    <= 1'b0;
            last_q      <= 2'd0;
            valid_o     <= 1'b0;
            rd_data_o   <= 32'd0;
            rd_addr_o   <= 5'd0;
            rd_enable_o <= 1'b0;
        end else begin
            valid_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (valid_i && in_mem) begin
                        cnt         <= 2'd0;
                        addr_q      <= mem_addr_i;
                        sdata_q     <= store_data_i;
                        load_buf    <= 32'd0;
                        rd_addr_q   <= rd_addr_i;
                        rd_enable_q <= rd_enable_i;
                        is_store_q  <= in_store;
                        signed_q    <= in_signed;
                        last_q      <= in_last;
                    end else if (valid_i) begin
                        valid_o     <= 1'b1;
                        rd_data_o   <= rd_data_i;
                        rd_addr_o   <= rd_addr_i;
                        rd_enable_o <= rd_enable_i;
                    end
                end
                REQ: begin
                    if (mem_gnt_i && is_store_q) begin
                        if (last_byte) begin
                            valid_o     <= 1'b1;
                            rd_data_o   <= 32'd0;
                            rd_addr_o   <= rd_addr_q;
                            rd_enable_o <= 1'b0;
                        end else begin
                            cnt <= cnt + 2'd1;
                        end
                    end
                end
                RECV: begin
                    load_buf <= load_asm;
                    if (last_byte) begin
                        valid_o     <= 1'b1;
                        rd_data_o   <= load_ext;
                        rd_addr_o   <= rd_addr_q;
                        rd_enable_o <= rd_enable_q;
                    end else begin
                        cnt <= cnt + 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed bench for mem_stage with a transaction-level model and memory responder.
// Latency: n/a (bench).
// Backpressure: the responder can withhold mem_gnt_i for a chosen byte address.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i;
    logic [31:0] rd_data_i;
    logic [4:0]  rd_addr_i;
    logic        rd_enable_i;
    logic [3:0]  mem_op_i;
    logic [31:0] mem_addr_i;
    logic [31:0] store_data_i;
    logic        stall_req_o;
    logic        valid_o;
    logic [31:0] rd_data_o;
    logic [4:0]  rd_addr_o;
    logic        rd_enable_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [7:0]  mem_wdata_o;
    logic        mem_gnt_i;
    logic [7:0]  mem_rdata_i;

    mem_stage #(.MEM_OP_LEN(4)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .rd_data_i(rd_data_i),
        .rd_addr_i(rd_addr_i), .rd_enable_i(rd_enable_i), .mem_op_i(mem_op_i),
        .mem_addr_i(mem_addr_i), .store_data_i(store_data_i), .stall_req_o(stall_req_o),
        .valid_o(valid_o), .rd_data_o(rd_data_o), .rd_addr_o(rd_addr_o),
        .rd_enable_o(rd_enable_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i),
        .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] data; logic [4:0] rd; logic en; } wb_t;
    typedef struct { logic we; logic [31:0] addr; logic [7:0] data; } acc_t;

    wb_t         exp_q[$];
    acc_t        acc_q[$];
    logic [7:0]  mem [logic [31:0]];

    int          tests = 0;
    int          failed = 0;
    int          cyc = 0;
    int          acc_cyc = 0;
    int          last_valid_cyc = -1;
    int          nvalid = 0;
    int          nreq = 0;
    int          denied = 0;
    int          deny_left = 0;
    logic [31:0] deny_addr = 32'd0;
    logic [31:0] last_data;
    logic        last_en;
    logic        stall_s;
    logic        saw_rd_gnt;
    logic [31:0] rd_gnt_addr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s actual=0x%08h expected=0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] mem_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 8'h00;
    endfunction

    // Transaction model: what the stage must emit for one instruction.
    task automatic model_push(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                              input logic [31:0] rdd, input logic [4:0] rd, input logic en);
        int          n;
        logic [31:0] v;
        wb_t         w;
        acc_t        a;
        case (op)
            4'd1, 4'd4, 4'd6: n = 1;
            4'd2, 4'd5, 4'd7: n = 2;
            4'd3, 4'd8:       n = 4;
            default:          n = 0;
        endcase
        if (n == 0) begin
            w = '{data: rdd, rd: rd, en: en};
        end else if (op >= 4'd6) begin
            for (int k = 0; k < n; k++) begin
                a = '{we: 1'b1, addr: addr + 32'(k), data: 8'((sdata >> (8 * k)) & 32'hFF)};
                acc_q.push_back(a);
            end
            w = '{data: 32'd0, rd: rd, en: 1'b0};
        end else begin
            v = 32'd0;
            for (int k = 0; k < n; k++) begin
                v = v | ({24'd0, mem_rd(addr + 32'(k))} << (8 * k));
                a = '{we: 1'b0, addr: addr + 32'(k), data: 8'd0};
                acc_q.push_back(a);
            end
            if (op == 4'd1 && v[7])  v = v | 32'hFFFF_FF00;
            if (op == 4'd2 && v[15]) v = v | 32'hFFFF_0000;
            w = '{data: v, rd: rd, en: en};
        end
        exp_q.push_back(w);
    endtask

    // One clock cycle: grant decision, compare against the model, memory responder.
    task automatic step();
        wb_t  w;
        acc_t a;
        @(negedge clk);
        mem_gnt_i = !(deny_left > 0 && mem_req_o && mem_addr_o == deny_addr);
        #1;
        cyc++;
        stall_s    = stall_req_o;
        saw_rd_gnt = 1'b0;
        if (valid_o) begin
            nvalid++;
            last_valid_cyc = cyc;
            last_data      = rd_data_o;
            last_en        = rd_enable_o;
            if (exp_q.size() == 0) begin
                chk("unexpected_valid", {31'd0, valid_o}, 32'd0);
            end else begin
                w = exp_q.pop_front();
                chk("wb_data", rd_data_o, w.data);
                chk("wb_addr", {27'd0, rd_addr_o}, {27'd0, w.rd});
                chk("wb_en", {31'd0, rd_enable_o}, {31'd0, w.en});
            end
        end
        if (mem_req_o) begin
            nreq++;
            if (!mem_gnt_i) begin
                deny_left--;
                denied++;
                chk("stall_during_wait", {31'd0, stall_req_o}, 32'd1);
            end else if (acc_q.size() == 0) begin
                chk("unexpected_req", {31'd0, mem_req_o}, 32'd0);
            end else begin
                a = acc_q.pop_front();
                chk("req_we", {31'd0, mem_we_o}, {31'd0, a.we});
                chk("req_addr", mem_addr_o, a.addr);
                if (a.we) begin
                    chk("req_wdata", {24'd0, mem_wdata_o}, {24'd0, a.data});
                    mem[mem_addr_o] = mem_wdata_o;
                end else begin
                    mem_rdata_i = mem_rd(mem_addr_o);
                    saw_rd_gnt  = 1'b1;
                    rd_gnt_addr = mem_addr_o;
                end
            end
        end else begin
            chk("idle_port", {mem_addr_o[23:0], mem_wdata_o}, 32'd0);
        end
        @(posedge clk);
        #1;
    endtask

    // Present one instruction and hold it until the stage stops stalling.
    task automatic issue(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                         input logic [31:0] rdd, input logic [4:0] rd, input logic en, output int n);
        model_push(op, addr, sdata, rdd, rd, en);
        valid_i = 1'b1; mem_op_i = op; mem_addr_i = addr; store_data_i = sdata;
        rd_data_i = rdd; rd_addr_i = rd; rd_enable_i = en;
        acc_cyc = cyc + 1;
        n = 0;
        do begin
            step();
            n++;
        end while (stall_s && n < 200);
        if (n >= 200) begin
            tests++; failed++;
            $display("FAIL issue_timeout op=%0d stalled for %0d cycles, limit 200", op, n);
        end
        valid_i = 1'b0; mem_op_i = 4'd0;
    endtask

    initial begin
        int n;
        int lat0;
        int lat1;
        int v0;
        int r0;
        rst = 1'b0; valid_i = 1'b0; rd_data_i = '0; rd_addr_i = '0; rd_enable_i = 1'b0;
        mem_op_i = '0; mem_addr_i = '0; store_data_i = '0; mem_gnt_i = 1'b1; mem_rdata_i = '0;
        mem[32'h100] = 8'h80; mem[32'h101] = 8'h01; mem[32'h102] = 8'h02; mem[32'h103] = 8'h03;
        mem[32'h104] = 8'hF0; mem[32'h105] = 8'h8F;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", {31'd0, valid_o}, 32'd0);
        chk("rst_rd_data", rd_data_o, 32'd0);
        chk("rst_rd_addr_en", {26'd0, rd_addr_o, rd_enable_o}, 32'd0);
        chk("rst_mem_port", {22'd0, mem_req_o, mem_we_o, mem_wdata_o}, 32'd0);
        chk("rst_mem_addr", mem_addr_o, 32'd0);
        chk("rst_stall", {31'd0, stall_req_o}, 32'd0);
        rst = 1'b1;
        step();

        // ALU passthrough
        issue(4'd0, 32'd0, 32'd0, 32'h0000_00FF, 5'd5, 1'b1, n);
        chk("pass_stall", {31'd0, stall_s}, 32'd0);
        step();
        chk("pass_latency", 32'(last_valid_cyc - acc_cyc), 32'd1);
        chk("pass_data", last_data, 32'h0000_00FF);

        // Back-to-back non-memory throughput
        v0 = nvalid;
        issue(4'd0, 32'd0, 32'd0, 32'h1111_1111, 5'd1, 1'b1, n);
        issue(4'd0, 32'd0, 32'd0, 32'h2222_2222, 5'd2, 1'b0, n);
        step();
        chk("b2b_count", 32'(nvalid - v0), 32'd2);
        chk("b2b_last", 32'(last_valid_cyc - acc_cyc), 32'd1);

        // Loads from 0x100..0x105
        issue(4'd3, 32'h100, 32'd0, 32'hDEAD, 5'd7, 1'b1, n);
        step();
        chk("lw_stall_cycles", 32'(n - 1), 32'd8);
        chk("lw_latency", 32'(last_valid_cyc - acc_cyc - 1), 32'd8);
        chk("lw_data", last_data, 32'h0302_0180);
        issue(4'd1, 32'h100, 32'd0, 32'd0, 5'd8, 1'b1, n);
        step();
        chk("lb_data", last_data, 32'hFFFF_FF80);
        issue(4'd4, 32'h100, 32'd0, 32'd0, 5'd8, 1'b1, n);
        step();
        chk("lbu_data", last_data, 32'h0000_0080);
        issue(4'd2, 32'h104, 32'd0, 32'd0, 5'd9, 1'b1, n);
        step();
        chk("lh_data", last_data, 32'hFFFF_8FF0);
        issue(4'd5, 32'h104, 32'd0, 32'd0, 5'd9, 1'b1, n);
        step();
        chk("lhu_data", last_data, 32'h0000_8FF0);
        issue(4'd2, 32'h101, 32'd0, 32'd0, 5'd10, 1'b1, n);
        step();
        chk("lh_misaligned", last_data, 32'h0000_0201);

        // Misaligned halfword store across the address wrap
        issue(4'd7, 32'hFFFF_FFFF, 32'h0000_BEEF, 32'h5555, 5'd11, 1'b1, n);
        step();
        chk("sh_byte0", {24'd0, mem_rd(32'hFFFF_FFFF)}, 32'h0000_00EF);
        chk("sh_byte1", {24'd0, mem_rd(32'h0000_0000)}, 32'h0000_00BE);
        chk("sh_en", {31'd0, last_en}, 32'd0);

        // Grant delay on byte 2 of a word store
        issue(4'd8, 32'h200, 32'h1122_3344, 32'd0, 5'd12, 1'b1, n);
        step();
        lat0 = last_valid_cyc - acc_cyc;
        denied = 0; deny_addr = 32'h302; deny_left = 3;
        issue(4'd8, 32'h300, 32'hA1B2_C3D4, 32'd0, 5'd13, 1'b1, n);
        step();
        lat1 = last_valid_cyc - acc_cyc;
        chk("gnt_denied_cycles", 32'(denied), 32'd3);
        chk("gnt_delay_latency", 32'(lat1 - lat0), 32'd3);
        chk("sw_byte2", {24'd0, mem_rd(32'h302)}, 32'h0000_00B2);

        // Illegal op code behaves as a non-memory instruction
        r0 = nreq;
        issue(4'd12, 32'h100, 32'hFFFF_FFFF, 32'h0000_1234, 5'd3, 1'b1, n);
        step();
        chk("illegal_no_req", 32'(nreq - r0), 32'd0);
        chk("illegal_latency", 32'(last_valid_cyc - acc_cyc), 32'd1);
        chk("illegal_data", last_data, 32'h0000_1234);

        // Reset while the second byte of a word load is being received
        model_push(4'd3, 32'h100, 32'd0, 32'h0, 5'd14, 1'b1);
        valid_i = 1'b1; mem_op_i = 4'd3; mem_addr_i = 32'h100; rd_addr_i = 5'd14; rd_enable_i = 1'b1;
        n = 0;
        do begin
            step();
            n++;
        end while (!(saw_rd_gnt && rd_gnt_addr == 32'h101) && n < 50);
        if (n >= 50) begin
            tests++; failed++;
            $display("FAIL rst_mid_load_setup no read grant at 0x101 within %0d cycles", n);
        end
        rst = 1'b0; valid_i = 1'b0; mem_op_i = 4'd0;
        v0 = nvalid;
        step();
        step();
        chk("midrst_no_valid", 32'(nvalid - v0), 32'd0);
        chk("midrst_rd_data", rd_data_o, 32'd0);
        chk("midrst_rd_addr_en", {26'd0, rd_addr_o, rd_enable_o}, 32'd0);
        chk("midrst_mem_port", {21'd0, mem_req_o, mem_we_o, stall_req_o, mem_wdata_o}, 32'd0);
        chk("midrst_mem_addr", mem_addr_o, 32'd0);
        exp_q.delete();
        acc_q.delete();
        rst = 1'b1;
        issue(4'd0, 32'd0, 32'd0, 32'h0000_CAFE, 5'd4, 1'b1, n);
        step();
        chk("post_rst_latency", 32'(last_valid_cyc - acc_cyc), 32'd1);
        chk("post_rst_data", last_data, 32'h0000_CAFE);

        step();
        step();
        chk("model_wb_drained", 32'(exp_q.size()), 32'd0);
        chk("model_acc_drained", 32'(acc_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
